data_fifo: RTL and testbench
============================

// Module: data_fifo
// PURPOSE
//  Parametrised synchronous FIFO with valid/ready handshakes on both sides; successor to the
//  single-register data stage. Decouples a producer and consumer running in the same clock
//  domain, adds DEPTH-entry buffering, occupancy reporting, almost-full warning and sync flush.
// PARAMETERS
//  DATA_WIDTH   32  width of each data word
//  DEPTH        4   number of entries, >= 2, need not be a power of two
//  ALMOST_FULL  3   count threshold at which almost_full_o asserts, 1..DEPTH
// PORTS
//  clk_i          in   1                     clock, all logic on rising edge
//  reset_n_i      in   1                     asynchronous reset, active low
//  flush_i        in   1                     synchronous flush, empties FIFO
//  in_valid_i     in   1                     producer has a word on in_data_i
//  in_ready_o     out  1                     FIFO can accept a word (not full)
//  in_data_i      in   DATA_WIDTH            write data
//  out_valid_o    out  1                     out_data_o holds the oldest word (not empty)
//  out_ready_i    in   1                     consumer takes the word this cycle
//  out_data_o     out  DATA_WIDTH            read data, show-ahead (head of queue)
//  count_o        out  $clog2(DEPTH+1)       current occupancy, 0..DEPTH
//  almost_full_o  out  1                     count_o >= ALMOST_FULL
// BEHAVIOUR
//  - Reset (reset_n_i low, async): wr_ptr=rd_ptr=0, count=0, storage=0; outputs in_ready_o=1,
//    out_valid_o=0, out_data_o=0, count_o=0, almost_full_o=0. Release is sync to clk_i.
//  - push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i. Nothing else moves state.
//  - in_ready_o = (count != DEPTH); out_valid_o = (count != 0); both decoded from registers,
//    no combinational path from in_valid_i/out_ready_i to any output.
//  - push: mem[wr_ptr] <= in_data_i, wr_ptr advances. pop: rd_ptr advances.
//  - Pointers wrap DEPTH-1 -> 0 explicitly (non-power-of-two DEPTH legal).
//  - count: +1 on push only, -1 on pop only, unchanged on push&pop or neither.
//  - Latency: a word pushed at edge N is visible on out_data_o with out_valid_o=1 after edge N
//    (one cycle); no same-cycle fall-through when empty.
//  - out_data_o = mem[rd_ptr] (show-ahead); stable while out_valid_o=1 and no pop.
//  - Full: in_ready_o=0; push&pop in same cycle not possible since push is blocked; pop alone
//    frees a slot next cycle.
//  - Empty: out_valid_o=0; a push in that cycle is accepted; out_data_o undefined-but-stable
//    (last head value) and must not be consumed.
//  - Simultaneous push&pop with 0<count<DEPTH: both proceed, count unchanged.
//  - flush_i: next edge sets wr_ptr=rd_ptr=count=0; overrides push/pop in that cycle (data
//    offered is dropped). Storage contents not cleared.
//  - Reset mid-operation: all contents discarded, state as at reset, regardless of handshakes.
//  - Producer rule (checked by bench, not enforced): in_data_i stable while in_valid_i & !in_ready_o.
// STRUCTURE
//  - No shared package entries required; pointer/count widths are local params from
//    $clog2(DEPTH) and $clog2(DEPTH+1).
//  - Sub-module fifo_mem: DEPTH x DATA_WIDTH register array, one write port (we, waddr, wdata),
//    one async read port (raddr -> rdata), async-reset to zero. Control, pointers and flags
//    live in data_fifo.
// TESTING  (DEPTH=4, ALMOST_FULL=3, DATA_WIDTH=32)
//  1 reset: assert reset_n_i mid-stream -> out_valid_o=0, in_ready_o=1, count_o=0, out_data_o=0
//    immediately, without a clock edge.
//  2 fill: push 0xA0..0xA3, out_ready_i=0 -> count_o 1,2,3,4; almost_full_o rises at count 3;
//    in_ready_o=0 at 4; 5th push 0xA4 held and not accepted.
//  3 drain: from full, out_ready_i=1 for 4 cycles -> out_data_o 0xA0,0xA1,0xA2,0xA3 in order,
//    out_valid_o=0 after, count_o=0; held 0xA4 then accepted as in_ready_o returns.
//  4 streaming: count=2, push and pop every cycle for 10 cycles -> count_o stays 2, data order
//    preserved across pointer wrap; also DEPTH=3 build wraps correctly.
//  5 flush: count=3, flush_i=1 with in_valid_i=1 and out_ready_i=1 -> next cycle count_o=0,
//    out_valid_o=0, offered word dropped.
//  6 random: random valid/ready for 10k cycles against a reference queue model -> no loss,
//    no duplication, no reorder; count_o always equals model depth.

Source files
------------

// File: rtl/data_fifo_pkg.sv
// Shared defaults for the data FIFO slice.
// Holds the parameter defaults used by the interface and the top.
package data_fifo_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_ALMOST_FULL = 3;

endpackage

// File: rtl/data_fifo_if.sv
// Producer/consumer bundle of the data FIFO.
// master: drives flush, write side and out_ready; slave: the FIFO.
interface data_fifo_if
  import data_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
);

  localparam int CW = $clog2(DEPTH + 1);

  logic                  flush_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic [CW-1:0]         count_o;
  logic                  almost_full_o;

  modport master (
    output flush_i,
    output in_valid_i,
    output in_data_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_data_o,
    input  count_o,
    input  almost_full_o
  );

  modport slave (
    input  flush_i,
    input  in_valid_i,
    input  in_data_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_data_o,
    output count_o,
    output almost_full_o
  );

endinterface

// File: rtl/data_fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH register array, async reset to zero.
// Ports: we/waddr/wdata write port, raddr -> rdata async read.
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AW         = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_fifo.sv
// data_fifo: synchronous valid/ready FIFO, show-ahead read side.
// Ports: clk_i, reset_n_i (async, low), bus (data_fifo_if.slave).
module data_fifo
  import data_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ALMOST_FULL = DEF_ALMOST_FULL
) (
  input  logic      clk_i,
  input  logic      reset_n_i,
  data_fifo_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF   = CW'(ALMOST_FULL);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          we;

  // Flags come from count only, so no input
  // reaches an output combinationally.
  assign bus.in_ready_o    = (count != FULL);
  assign bus.out_valid_o   = (count != '0);
  assign bus.count_o       = count;
  assign bus.almost_full_o = (count >= AF);

  assign push = bus.in_valid_i & bus.in_ready_o;
  assign pop  = bus.out_valid_o & bus.out_ready_i;

  // Flush drops the offered word.
  assign we = push & ~bus.flush_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_mem (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .we        (we),
    .waddr     (wr_ptr),
    .wdata     (bus.in_data_i),
    .raddr     (rd_ptr),
    .rdata     (bus.out_data_o)
  );

endmodule

// File: tb/tb_data_fifo.sv
// Self-checking bench for data_fifo.
// Directed scenarios plus a queue-model random run; DEPTH 4 and 3.
module tb_data_fifo;

  logic clk_i = 1'b0;
  logic reset_n_i;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  data_fifo_if #(.DATA_WIDTH(32), .DEPTH(4)) bus ();
  data_fifo_if #(.DATA_WIDTH(32), .DEPTH(3)) bus3 ();

  data_fifo #(.DATA_WIDTH(32), .DEPTH(4), .ALMOST_FULL(3)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

  data_fifo #(.DATA_WIDTH(32), .DEPTH(3), .ALMOST_FULL(2)) dut3 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus3)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.flush_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    idle();
    bus3.flush_i = 1'b0;
    bus3.in_valid_i = 1'b0;
    bus3.in_data_i = '0;
    bus3.out_ready_i = 1'b0;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 ||
        bus.count_o !== 3'd0 || bus.almost_full_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: v=%b r=%b c=%0d af=%b exp 0 1 0 0",
               bus.out_valid_o, bus.in_ready_o, bus.count_o, bus.almost_full_o);
    end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step();
    bus.in_valid_i = 1'b1;
    bus.in_data_i = 32'h55;
    step();
    bus.in_data_i = 32'h66;
    step();
    bus.in_valid_i = 1'b0;
    checks++;
    if (bus.count_o !== 3'd2 || bus.out_data_o !== 32'h55) begin
      errors++;
      $display("FAIL reset_pre: c=%0d d=%h exp 2 00000055", bus.count_o, bus.out_data_o);
    end
    #3;
    reset_n_i = 1'b0;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 ||
        bus.count_o !== 3'd0 || bus.out_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: v=%b r=%b c=%0d d=%h exp 0 1 0 0",
               bus.out_valid_o, bus.in_ready_o, bus.count_o, bus.out_data_o);
    end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    step();
  endtask

  task automatic test_fill();
    bus.in_valid_i = 1'b1;
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_data_i = 32'hA0 + i;
      step();
      checks++;
      if (bus.count_o !== 3'(i + 1) || bus.almost_full_o !== (i >= 2) ||
          bus.in_ready_o !== (i < 3)) begin
        errors++;
        $display("FAIL fill_%0d: c=%0d af=%b r=%b exp %0d %b %b", i,
                 bus.count_o, bus.almost_full_o, bus.in_ready_o,
                 i + 1, (i >= 2), (i < 3));
      end
    end
    bus.in_data_i = 32'hA4;
    step();
    checks++;
    if (bus.count_o !== 3'd4 || bus.in_ready_o !== 1'b0 ||
        bus.out_data_o !== 32'hA0) begin
      errors++;
      $display("FAIL fill_held: c=%0d r=%b d=%h exp 4 0 000000a0",
               bus.count_o, bus.in_ready_o, bus.out_data_o);
    end
  endtask

  task automatic test_drain();
    logic acc;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'hA0 + i) begin
        errors++;
        $display("FAIL drain_%0d: v=%b d=%h exp 1 %h", i,
                 bus.out_valid_o, bus.out_data_o, 32'hA0 + i);
      end
      acc = bus.in_valid_i & bus.in_ready_o;
      step();
      if (acc) bus.in_valid_i = 1'b0;
    end
    checks++;
    if (bus.in_valid_i !== 1'b0 || bus.count_o !== 3'd1 ||
        bus.out_data_o !== 32'hA4) begin
      errors++;
      $display("FAIL drain_held: iv=%b c=%0d d=%h exp 0 1 000000a4",
               bus.in_valid_i, bus.count_o, bus.out_data_o);
    end
    step();
    bus.out_ready_i = 1'b0;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.count_o !== 3'd0 ||
        bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: v=%b c=%0d r=%b exp 0 0 1",
               bus.out_valid_o, bus.count_o, bus.in_ready_o);
    end
  endtask

  task automatic test_streaming();
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_data_i = 32'hB0 + i;
      step();
    end
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data_i = 32'hB2 + i;
      checks++;
      if (bus.out_data_o !== 32'hB0 + i || bus.out_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL stream_d%0d: d=%h exp %h", i, bus.out_data_o, 32'hB0 + i);
      end
      step();
      checks++;
      if (bus.count_o !== 3'd2) begin
        errors++;
        $display("FAIL stream_c%0d: c=%0d exp 2", i, bus.count_o);
      end
    end
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.out_data_o !== 32'hBA + i) begin
        errors++;
        $display("FAIL stream_tail%0d: d=%h exp %h", i, bus.out_data_o, 32'hBA + i);
      end
      step();
    end
    bus.out_ready_i = 1'b0;
    checks++;
    if (bus.count_o !== 3'd0) begin
      errors++;
      $display("FAIL stream_end: c=%0d exp 0", bus.count_o);
    end
  endtask

  task automatic test_flush();
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data_i = 32'hC0 + i;
      step();
    end
    bus.in_data_i = 32'hC3;
    bus.out_ready_i = 1'b1;
    bus.flush_i = 1'b1;
    step();
    idle();
    checks++;
    if (bus.count_o !== 3'd0 || bus.out_valid_o !== 1'b0 ||
        bus.in_ready_o !== 1'b1 || bus.almost_full_o !== 1'b0) begin
      errors++;
      $display("FAIL flush: c=%0d v=%b r=%b af=%b exp 0 0 1 0",
               bus.count_o, bus.out_valid_o, bus.in_ready_o, bus.almost_full_o);
    end
    bus.in_valid_i = 1'b1;
    bus.in_data_i = 32'hD0;
    step();
    bus.in_valid_i = 1'b0;
    checks++;
    if (bus.count_o !== 3'd1 || bus.out_data_o !== 32'hD0) begin
      errors++;
      $display("FAIL flush_after: c=%0d d=%h exp 1 000000d0",
               bus.count_o, bus.out_data_o);
    end
    bus.out_ready_i = 1'b1;
    step();
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_depth3();
    bus3.in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus3.in_data_i = 32'hE0 + i;
      step();
    end
    bus3.in_valid_i = 1'b0;
    checks++;
    if (bus3.count_o !== 2'd3 || bus3.in_ready_o !== 1'b0 ||
        bus3.almost_full_o !== 1'b1) begin
      errors++;
      $display("FAIL d3_full: c=%0d r=%b af=%b exp 3 0 1",
               bus3.count_o, bus3.in_ready_o, bus3.almost_full_o);
    end
    bus3.out_ready_i = 1'b1;
    step();
    bus3.in_valid_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus3.in_data_i = 32'hE3 + i;
      checks++;
      if (bus3.out_data_o !== 32'hE1 + i) begin
        errors++;
        $display("FAIL d3_stream%0d: d=%h exp %h", i, bus3.out_data_o, 32'hE1 + i);
      end
      step();
      checks++;
      if (bus3.count_o !== 2'd2) begin
        errors++;
        $display("FAIL d3_count%0d: c=%0d exp 2", i, bus3.count_o);
      end
    end
    bus3.in_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus3.out_data_o !== 32'hE8 + i) begin
        errors++;
        $display("FAIL d3_tail%0d: d=%h exp %h", i, bus3.out_data_o, 32'hE8 + i);
      end
      step();
    end
    bus3.out_ready_i = 1'b0;
    checks++;
    if (bus3.out_valid_o !== 1'b0 || bus3.count_o !== 2'd0) begin
      errors++;
      $display("FAIL d3_empty: v=%b c=%0d exp 0 0", bus3.out_valid_o, bus3.count_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic        push;
    logic        pop;
    int          bad = 0;
    logic [31:0] seq = 32'h1000;
    for (int n = 0; n < 10000; n++) begin
      // Keep an offered word stable until it is taken.
      if (!(bus.in_valid_i && q.size() == 4)) begin
        bus.in_valid_i = 1'($urandom_range(0, 1));
        bus.in_data_i = seq;
      end
      bus.out_ready_i = 1'($urandom_range(0, 1));
      #1;
      push = bus.in_valid_i && (q.size() < 4);
      pop = bus.out_ready_i && (q.size() > 0);
      checks++;
      if (bus.in_ready_o !== (q.size() < 4) ||
          bus.out_valid_o !== (q.size() > 0) ||
          (q.size() > 0 && bus.out_data_o !== q[0])) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_out@%0d: r=%b v=%b d=%h exp r=%b v=%b d=%h", n,
                   bus.in_ready_o, bus.out_valid_o, bus.out_data_o,
                   (q.size() < 4), (q.size() > 0),
                   (q.size() > 0) ? q[0] : 32'h0);
      end
      step();
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(bus.in_data_i);
        seq++;
        bus.in_data_i = seq;
      end
      checks++;
      if (bus.count_o !== 3'(q.size())) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_count@%0d: c=%0d exp %0d", n, bus.count_o, q.size());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_streaming();
    test_flush();
    test_depth3();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
